commit_monitor: RTL and testbench
=================================

Name: commit_monitor

Overview:
- End-of-run responder for the pipelined RISC core.
- The bench drives clk/rst_n and preloads memory. This block watches the core's writeback and data-memory store ports and decides when the program has finished.
- Reports pass/fail, retired-instruction and cycle counts, and a 32-bit MISR signature of all architectural register writes.
- Sits beside `top`; the bench samples `done` instead of running a fixed cycle budget.

Parameters:
- TOHOST_ADDR, 32'h0000_FFFC, store address that signals program end.
- MAX_CYC, 300, cycle budget before a timeout is declared.
- DRAIN_CYC, 4, cycles to keep observing after the tohost store so in-flight writebacks retire.
- LOOP_CYC, 16, consecutive cycles with an unchanged `if_pc` that count as a halt self-loop.
- EXP_SIG, 32'h0000_0000, expected signature (used only with SIG_CHECK_EN).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- wb_en, input, 1, register-file write this cycle.
- wb_rd, input, 5, destination register.
- wb_data, input, 32, writeback value.
- if_pc, input, 32, current fetch PC.
- dm_we, input, 1, data-memory store this cycle.
- dm_addr, input, 32, store address.
- dm_wdata, input, 32, store data.
- done, output, 1, run finished (sticky until reset).
- pass, output, 1, valid when done=1.
- timeout, output, 1, done was caused by MAX_CYC.
- fail_code, output, 31, dm_wdata[31:1] of the tohost store.
- retire_cnt, output, 32, count of counted writebacks.
- cycle_cnt, output, 32, cycles spent in RUN and DRAIN.
- signature, output, 32, MISR value.

Behaviour:
- Reset values: state=RUN, signature=32'hFFFF_FFFF, all counters 0, and done, pass, timeout, fail_code all 0.
- States: RUN, DRAIN, DONE.
- Counted writeback: wb_en=1 and wb_rd!=0. Writes to r0 are ignored entirely.
- In RUN and DRAIN, each counted writeback does two things in the same edge:
  - retire_cnt += 1, saturating at all-ones.
  - signature <= ({sig[30:0], fb} ^ wb_data ^ {27'b0, wb_rd}), where fb = sig[31]^sig[21]^sig[1]^sig[0].
- cycle_cnt increments every cycle in RUN and DRAIN (saturating) and freezes in DONE.
- Loop counter: counts cycles with if_pc equal to its registered previous value. It resets to 0 on any PC change.
- RUN -> DRAIN when dm_we=1 and dm_addr==TOHOST_ADDR. In the same edge:
  - latch pass=(dm_wdata==1).
  - latch fail_code=dm_wdata[31:1].
- RUN -> DRAIN on a self-loop (loop counter reaches LOOP_CYC-1 with PC still unchanged). Then pass=0 and fail_code=31'h7FFF_FFFF.
- DRAIN lasts exactly DRAIN_CYC cycles, then -> DONE with done=1. Additional tohost stores in DRAIN are ignored.
- RUN or DRAIN -> DONE with timeout=1 and pass=0 when cycle_cnt reaches MAX_CYC-1 at the clock edge.
- Simultaneous events in RUN:
  - tohost store beats self-loop, which beats timeout.
  - A timeout during DRAIN still forces DONE with timeout=1 and pass=0.
- DONE is absorbing: all inputs are ignored and outputs hold until rst_n=0.
- Reset asserted mid-run clears everything asynchronously. Monitoring resumes in RUN on the first edge after release.
- No combinational paths from inputs to outputs; every output is a register.

Optional Feature:
- Macro: COMMIT_MONITOR_SIG_CHECK_EN.
- Defined: on entry to DONE via the tohost path, pass = (dm_wdata==1) AND (final signature==EXP_SIG). The final signature includes drain-window writebacks. A mismatch sets fail_code=31'h7FFF_FFFE.
- Undefined: EXP_SIG is unused, and pass depends only on the tohost data.

Decomposition:
- Package commit_monitor_pkg holds:
  - state enum (RUN, DRAIN, DONE).
  - MISR reset seed 32'hFFFF_FFFF.
  - tap constants 31/21/1/0.
  - fail codes 7FFF_FFFF (loop) and 7FFF_FFFE (signature).
- Sub-module commit_misr: 32-bit MISR with enable, data and rd inputs, async reset to the seed. The top module holds the FSM and counters.

Test Plan:
- Writeback rd=1, data=5 from reset -> signature=FFFF_FFFA, retire_cnt=1.
- Writeback to rd=0, data=1234 -> signature stays FFFF_FFFF, retire_cnt stays 0.
- Store 1 to FFFC at cycle 10, plus two writebacks in the drain window -> done rises exactly 4 cycles later; pass=1; retire_cnt includes the drain writebacks; cycle_cnt frozen at 14.
- Store 7 to FFFC -> done, pass=0, fail_code=3.
- PC held at 0x40 for 16 cycles, no store -> DRAIN, then done with pass=0, fail_code=7FFF_FFFF.
- Idle program with constantly changing PC -> done at cycle 300 with timeout=1, pass=0.
- Reset pulsed during DRAIN -> all outputs return to reset values; done stays 0 until a new end condition occurs.

Source files
------------

// File: rtl/commit_monitor_pkg.sv
// Shared types, constants and the MISR step function for commit_monitor.
package commit_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } cm_state_e;

  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

  localparam int TAP_0 = 31;
  localparam int TAP_1 = 21;
  localparam int TAP_2 = 1;
  localparam int TAP_3 = 0;

  localparam logic [30:0] FAIL_LOOP = 31'h7FFF_FFFF;
  localparam logic [30:0] FAIL_SIG  = 31'h7FFF_FFFE;

  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [31:0] data,
                                            input logic [4:0]  rd);
    logic fb;
    fb = sig[TAP_0] ^ sig[TAP_1] ^ sig[TAP_2] ^ sig[TAP_3];
    return {sig[30:0], fb} ^ data ^ {27'b0, rd};
  endfunction

endpackage

// File: rtl/commit_misr.sv
// 32-bit MISR folding architectural register writes into a signature.
module commit_misr
  import commit_monitor_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] data,
  input  logic [4:0]  rd,
  output logic [31:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  sig <= MISR_SEED;
    else if (en) sig <= misr_next(sig, data, rd);
  end

endmodule

// File: rtl/commit_monitor.sv
// End-of-run monitor: detects tohost store, halt self-loop or timeout.
// Optional COMMIT_MONITOR_SIG_CHECK_EN also requires signature == EXP_SIG.
module commit_monitor
  import commit_monitor_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_FFFC,
  parameter int          MAX_CYC     = 300,
  parameter int          DRAIN_CYC   = 4,
  parameter int          LOOP_CYC    = 16,
  parameter logic [31:0] EXP_SIG     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic [31:0] if_pc,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] fail_code,
  output logic [31:0] retire_cnt,
  output logic [31:0] cycle_cnt,
  output logic [31:0] signature
);

  localparam int LW = $clog2(LOOP_CYC) + 1;
  localparam int DW = $clog2(DRAIN_CYC) + 1;
  localparam logic [31:0]   MAX_HIT   = 32'(MAX_CYC - 1);
  localparam logic [31:0]   LOOP_HIT  = 32'(LOOP_CYC - 2);
  localparam logic [DW-1:0] DRAIN_END = DW'(DRAIN_CYC - 1);

  cm_state_e     state_q, state_d;
  logic [31:0]   prev_pc_q;
  logic [LW-1:0] loop_q;
  logic [DW-1:0] drain_q;
  logic          tohost_q, tohost_d;
  logic          done_d, pass_d, timeout_d;
  logic [30:0]   fail_d;

  logic active, counted, sig_en, tohost, pc_same, self_loop, timeout_hit, drain_end;

  assign active      = (state_q != ST_DONE);
  assign counted     = wb_en && (wb_rd != 5'd0);
  assign sig_en      = active && counted;
  assign tohost      = dm_we && (dm_addr == TOHOST_ADDR);
  assign pc_same     = (if_pc == prev_pc_q);
  // Fires on the edge where the unchanged-PC count would reach LOOP_CYC-1.
  assign self_loop   = pc_same && (32'(loop_q) == LOOP_HIT);
  assign timeout_hit = (cycle_cnt == MAX_HIT);
  assign drain_end   = (drain_q == DRAIN_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (tohost || self_loop) state_d = ST_DRAIN;
        else if (timeout_hit)    state_d = ST_DONE;
      end
      ST_DRAIN: if (timeout_hit || drain_end) state_d = ST_DONE;
      default:  state_d = ST_DONE;
    endcase
  end

`ifdef COMMIT_MONITOR_SIG_CHECK_EN
  logic [31:0] sig_final;
  assign sig_final = sig_en ? misr_next(signature, wb_data, wb_rd) : signature;
`else
  logic unused_cfg;
  assign unused_cfg = ^{EXP_SIG, FAIL_SIG, tohost_q};
`endif

  always_comb begin
    done_d    = done;
    pass_d    = pass;
    timeout_d = timeout;
    fail_d    = fail_code;
    tohost_d  = tohost_q;
    case (state_q)
      ST_RUN: begin
        if (tohost) begin
          pass_d   = (dm_wdata == 32'd1);
          fail_d   = dm_wdata[31:1];
          tohost_d = 1'b1;
        end else if (self_loop) begin
          pass_d = 1'b0;
          fail_d = FAIL_LOOP;
        end else if (timeout_hit) begin
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (timeout_hit) begin
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else if (drain_end) begin
          done_d = 1'b1;
`ifdef COMMIT_MONITOR_SIG_CHECK_EN
          if (tohost_q && (sig_final != EXP_SIG)) begin
            pass_d = 1'b0;
            fail_d = FAIL_SIG;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      fail_code  <= 31'd0;
      tohost_q   <= 1'b0;
      retire_cnt <= 32'd0;
      cycle_cnt  <= 32'd0;
      prev_pc_q  <= 32'd0;
      loop_q     <= '0;
      drain_q    <= '0;
    end else begin
      done      <= done_d;
      pass      <= pass_d;
      timeout   <= timeout_d;
      fail_code <= fail_d;
      tohost_q  <= tohost_d;
      if (active && (cycle_cnt != '1))            cycle_cnt  <= cycle_cnt + 32'd1;
      if (sig_en && (retire_cnt != '1))           retire_cnt <= retire_cnt + 32'd1;
      prev_pc_q <= if_pc;
      if (!pc_same)          loop_q <= '0;
      else if (loop_q != '1) loop_q <= loop_q + 1'b1;
      drain_q <= (state_q == ST_DRAIN) ? drain_q + 1'b1 : '0;
    end
  end

  commit_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sig_en),
    .data  (wb_data),
    .rd    (wb_rd),
    .sig   (signature)
  );

endmodule

// File: tb/tb_commit_monitor.sv
// Scoreboard bench for commit_monitor: an event-scan reference model predicts
// the final report, a monitor compares it when done rises and again later.
module tb_commit_monitor;

  localparam int          NCYC      = 320;
  localparam int          MAX_CYC   = 300;
  localparam int          DRAIN_CYC = 4;
  localparam int          LOOP_CYC  = 16;
  localparam logic [31:0] TOHOST    = 32'h0000_FFFC;
  localparam logic [31:0] EXP_SIG   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wb_en = 1'b0, dm_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0, if_pc = '0, dm_addr = '0, dm_wdata = '0;
  logic done, pass, timeout;
  logic [30:0] fail_code;
  logic [31:0] retire_cnt, cycle_cnt, signature;

  always #5 clk = ~clk;

  commit_monitor #(
    .TOHOST_ADDR(TOHOST), .MAX_CYC(MAX_CYC), .DRAIN_CYC(DRAIN_CYC),
    .LOOP_CYC(LOOP_CYC), .EXP_SIG(EXP_SIG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .if_pc(if_pc), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .done(done), .pass(pass), .timeout(timeout), .fail_code(fail_code),
    .retire_cnt(retire_cnt), .cycle_cnt(cycle_cnt), .signature(signature)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cur_idx  = -1;
  bit mon_fin  = 0;

  // Expected report: {pass, timeout, fail_code, retire, cycles, signature}.
  logic [128:0] exp_q[$];
  int           exp_idx_q[$];

  logic        p_wb_en[NCYC];
  logic [4:0]  p_wb_rd[NCYC];
  logic [31:0] p_wb_data[NCYC];
  logic [31:0] p_pc[NCYC];
  logic        p_dm_we[NCYC];
  logic [31:0] p_dm_addr[NCYC];
  logic [31:0] p_dm_wdata[NCYC];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [31:0] d,
                                           input logic [4:0] r);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb} ^ d ^ {27'b0, r};
  endfunction

  // Find the first end event by scanning the program, then fold the
  // counted writebacks up to the cycle where the run is declared over.
  task automatic model_run(output logic [128:0] rec, output int didx);
    int e = -1;
    int run = 0;
    bit by_tohost = 0;
    logic [31:0] prev = 32'd0;
    logic [31:0] s = 32'hFFFF_FFFF;
    logic [31:0] ret = 32'd0;
    logic ps, to;
    logic [30:0] fc;
    for (int i = 0; i < MAX_CYC; i++) begin
      run  = (p_pc[i] == prev) ? run + 1 : 0;
      prev = p_pc[i];
      if (p_dm_we[i] && p_dm_addr[i] == TOHOST) begin e = i; by_tohost = 1; break; end
      if (run == LOOP_CYC - 1) begin e = i; break; end
    end
    fc = 31'd0;
    if (e >= 0) fc = by_tohost ? p_dm_wdata[e][31:1] : 31'h7FFF_FFFF;
    if (e < 0 || (e < MAX_CYC - 1 && e + DRAIN_CYC >= MAX_CYC - 1)) begin
      didx = MAX_CYC - 1; to = 1'b1; ps = 1'b0;
    end else begin
      didx = e + DRAIN_CYC; to = 1'b0;
      ps = by_tohost && (p_dm_wdata[e] == 32'd1);
    end
    for (int i = 0; i <= didx; i++)
      if (p_wb_en[i] && p_wb_rd[i] != 5'd0) begin
        s = sig_step(s, p_wb_data[i], p_wb_rd[i]);
        ret++;
      end
`ifdef COMMIT_MONITOR_SIG_CHECK_EN
    if (!to && by_tohost && s != EXP_SIG) begin ps = 1'b0; fc = 31'h7FFF_FFFE; end
`endif
    rec = {ps, to, fc, ret, 32'(didx + 1), s};
  endtask

  task automatic gen_idle();
    for (int i = 0; i < NCYC; i++) begin
      p_wb_en[i] = 1'b0; p_wb_rd[i] = 5'd0; p_wb_data[i] = 32'd0;
      p_pc[i] = 32'h100 + 32'(4 * i);
      p_dm_we[i] = 1'b0; p_dm_addr[i] = 32'd0; p_dm_wdata[i] = 32'd0;
    end
  endtask

  // kind 0: tohost end, 1: self-loop end, 2: timeout.
  task automatic gen_random(input int kind);
    int s = $urandom_range(20, 200);
    logic [31:0] pc = 32'h200;
    for (int i = 0; i < NCYC; i++) begin
      p_wb_en[i]   = 1'($urandom_range(0, 1));
      p_wb_rd[i]   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      p_wb_data[i] = $urandom;
      if (!(kind == 1 && i >= s) && $urandom_range(0, 9) != 0) pc = pc + 32'd4;
      p_pc[i]       = pc;
      p_dm_we[i]    = ($urandom_range(0, 3) == 0);
      p_dm_addr[i]  = 32'h1000 + 32'(4 * $urandom_range(0, 255));
      p_dm_wdata[i] = $urandom;
      if (kind == 0 && i == s) begin
        p_dm_we[i] = 1'b1; p_dm_addr[i] = TOHOST;
        p_dm_wdata[i] = $urandom_range(0, 1) ? 32'd1 : 32'($urandom_range(2, 999));
      end
      if (kind == 0 && i > s && i <= s + 3 && $urandom_range(0, 1) == 0) begin
        p_dm_we[i] = 1'b1; p_dm_addr[i] = TOHOST; p_dm_wdata[i] = 32'd9;
      end
    end
  endtask

  task automatic apply(input int i);
    wb_en = p_wb_en[i]; wb_rd = p_wb_rd[i]; wb_data = p_wb_data[i];
    if_pc = p_pc[i]; dm_we = p_dm_we[i]; dm_addr = p_dm_addr[i];
    dm_wdata = p_dm_wdata[i];
    cur_idx = i;
  endtask

  // Leaves rst_n released at a negedge; the next rising edge is index 0.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; wb_en = 1'b0; dm_we = 1'b0; cur_idx = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check32({tag, "_done"},    32'(done),    32'd0);
    check32({tag, "_pass"},    32'(pass),    32'd0);
    check32({tag, "_timeout"}, 32'(timeout), 32'd0);
    check32({tag, "_fail"},    32'(fail_code), 32'd0);
    check32({tag, "_retire"},  retire_cnt,   32'd0);
    check32({tag, "_cycle"},   cycle_cnt,    32'd0);
    check32({tag, "_sig"},     signature,    32'hFFFF_FFFF);
  endtask

  task automatic run_test(input string name, input bit with_reset);
    logic [128:0] rec;
    int didx;
    model_run(rec, didx);
    // Post-done traffic must be ignored.
    for (int i = didx + 1; i < NCYC; i++) begin
      p_wb_en[i] = 1'b1; p_wb_rd[i] = 5'd3;
      p_dm_we[i] = 1'b1; p_dm_addr[i] = TOHOST; p_dm_wdata[i] = 32'd1;
    end
    exp_q.push_back(rec);
    exp_idx_q.push_back(didx);
    mon_fin = 0;
    if (with_reset) do_reset();
    for (int i = 0; i < NCYC; i++) begin
      apply(i);
      @(negedge clk);
      if (mon_fin) break;
    end
    if (!mon_fin) begin
      n_checks++;
      $display("FAIL %s done_wait: done=%0b after %0d cycles, expected rise at %0d",
               name, done, NCYC, didx);
      void'(exp_q.pop_front());
      void'(exp_idx_q.pop_front());
    end
  endtask

  task automatic compare_report(input string tag, input logic [128:0] rec);
    check32({tag, "_done"},    32'(done),      32'd1);
    check32({tag, "_pass"},    32'(pass),      32'(rec[128]));
    check32({tag, "_timeout"}, 32'(timeout),   32'(rec[127]));
    check32({tag, "_fail"},    32'(fail_code), 32'(rec[126:96]));
    check32({tag, "_retire"},  retire_cnt,     rec[95:64]);
    check32({tag, "_cycle"},   cycle_cnt,      rec[63:32]);
    check32({tag, "_sig"},     signature,      rec[31:0]);
  endtask

  initial begin : monitor
    bit prev_done = 0;
    logic [128:0] rec;
    int di;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) prev_done = 0;
      else if (done && !prev_done) begin
        prev_done = 1;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: done=1 at index %0d, no end expected", cur_idx);
        end else begin
          rec = exp_q.pop_front();
          di  = exp_idx_q.pop_front();
          check32("done_index", 32'(cur_idx), 32'(di));
          compare_report("at_done", rec);
          repeat (5) @(posedge clk);
          #1;
          compare_report("absorb", rec);
        end
        mon_fin = 1;
      end
    end
  end

  initial begin : driver
    @(negedge clk);
    #1;
    check_reset_vals("reset");
    do_reset();

    gen_idle();
    p_wb_en[0] = 1'b1; p_wb_rd[0] = 5'd1; p_wb_data[0] = 32'd5;
    do_reset(); apply(0); @(negedge clk);
    check32("wb_rd1_sig", signature, 32'hFFFF_FFFA);
    check32("wb_rd1_retire", retire_cnt, 32'd1);
    check32("wb_rd1_cycle", cycle_cnt, 32'd1);

    gen_idle();
    p_wb_en[0] = 1'b1; p_wb_rd[0] = 5'd0; p_wb_data[0] = 32'd1234;
    do_reset(); apply(0); @(negedge clk);
    check32("wb_r0_sig", signature, 32'hFFFF_FFFF);
    check32("wb_r0_retire", retire_cnt, 32'd0);

    gen_idle();
    p_dm_we[9] = 1'b1; p_dm_addr[9] = TOHOST; p_dm_wdata[9] = 32'd1;
    p_wb_en[10] = 1'b1; p_wb_rd[10] = 5'd4; p_wb_data[10] = 32'hDEAD_0001;
    p_wb_en[12] = 1'b1; p_wb_rd[12] = 5'd7; p_wb_data[12] = 32'h0BAD_F00D;
    p_dm_we[11] = 1'b1; p_dm_addr[11] = TOHOST; p_dm_wdata[11] = 32'd7;
    run_test("tohost_pass", 1);

    gen_idle();
    p_dm_we[30] = 1'b1; p_dm_addr[30] = TOHOST; p_dm_wdata[30] = 32'd7;
    run_test("tohost_fail7", 1);

    gen_idle();
    for (int i = 5; i < NCYC; i++) p_pc[i] = 32'h40;
    run_test("self_loop", 1);

    gen_idle();
    run_test("timeout", 1);

    gen_idle();
    p_dm_we[5] = 1'b1; p_dm_addr[5] = TOHOST; p_dm_wdata[5] = 32'd1;
    p_wb_en[3] = 1'b1; p_wb_rd[3] = 5'd2; p_wb_data[3] = 32'h55;
    do_reset();
    for (int i = 0; i <= 6; i++) begin apply(i); @(negedge clk); end
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid_drain");
    @(negedge clk);
    rst_n = 1'b1;
    gen_random(1);
    run_test("after_reset", 0);

    for (int t = 0; t < 9; t++) begin
      gen_random(t % 3);
      run_test($sformatf("rand%0d", t), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
